// File: rtl/tensor_core_register_file_controller.sv
// Tensor core register file controller.
// Streams operand bytes into the register file, pulses start to the tensor
// core, and gates the result bulk write on done. It then streams result bytes
// out and returns to accept the next load.
module tensor_core_register_file_controller #(
   parameter int NUMBER_OF_REGISTERS = 32,
   parameter int UNLOAD_COUNT        = 16
) (
   input  logic                                            clock_in,
   input  logic                                            reset_n_in,
   input  logic                                            load_valid_in,
   input  logic [7:0]                                      load_data_in,
   output logic                                            load_ready_out,
   output logic                                            unload_valid_out,
   output logic [7:0]                                      unload_data_out,
   input  logic                                            unload_ready_in,
   output logic                                            compute_start_out,
   input  logic                                            compute_done_in,
   output logic                                            rf_non_bulk_write_enable_out,
   output logic [$clog2(NUMBER_OF_REGISTERS)-1:0]          rf_non_bulk_write_register_address_out,
   output logic [7:0]                                      rf_non_bulk_write_data_out,
   output logic                                            rf_bulk_write_enable_out,
   input  logic [NUMBER_OF_REGISTERS/16-1:0][3:0][3:0][7:0] rf_read_data_in,
   output logic                                            busy_out,
   output logic [7:0]                                      operation_count_out
);

   localparam int AW = $clog2(NUMBER_OF_REGISTERS);
   localparam int M  = NUMBER_OF_REGISTERS / 16;

   localparam logic [AW:0] LOAD_LAST   = (AW + 1)'(NUMBER_OF_REGISTERS - 1);
   localparam logic [AW:0] UNLOAD_LAST = (AW + 1)'(UNLOAD_COUNT - 1);
   localparam logic [AW:0] COUNT_ONE   = (AW + 1)'(1);

   typedef enum logic [1:0] {
      ST_LOAD   = 2'd0,
      ST_START  = 2'd1,
      ST_WAIT   = 2'd2,
      ST_UNLOAD = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [AW:0] load_count_q, load_count_d;
   logic [AW:0] unload_count_q, unload_count_d;
   logic [7:0]  op_count_q, op_count_d;

   // State-decoded control outputs are held in flops so they leave the block glitch-free.
   logic load_ready_q, load_ready_d;
   logic start_q, start_d;
   logic unload_valid_q, unload_valid_d;

   logic load_hs_s;
   logic unload_hs_s;
   logic bulk_we_s;

   // The read bus is packed [M][4][4] bytes; viewed flat, byte c sits at element c.
   logic [M*16-1:0][7:0] rf_bytes_s;

   assign rf_bytes_s = rf_read_data_in;

   // Handshake detection; reset low suppresses any register-file write.
   always_comb begin
      load_hs_s   = load_ready_q & load_valid_in & reset_n_in;
      unload_hs_s = unload_valid_q & unload_ready_in;
      bulk_we_s   = (state_q == ST_WAIT) & compute_done_in & reset_n_in;
   end

   // Next-state, counter and registered-output computation.
   always_comb begin
      state_d        = state_q;
      load_count_d   = load_count_q;
      unload_count_d = unload_count_q;
      op_count_d     = op_count_q;
      case (state_q)
         ST_LOAD: begin
            if (load_hs_s) begin
               if (load_count_q == LOAD_LAST) begin
                  load_count_d = '0;
                  state_d      = ST_START;
               end else begin
                  load_count_d = load_count_q + COUNT_ONE;
               end
            end else begin
               load_count_d = load_count_q;
            end
         end
         ST_START: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (compute_done_in) begin
               unload_count_d = '0;
               state_d        = ST_UNLOAD;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_UNLOAD: begin
            if (unload_hs_s) begin
               if (unload_count_q == UNLOAD_LAST) begin
                  unload_count_d = '0;
                  op_count_d     = op_count_q + 8'd1;
                  state_d        = ST_LOAD;
               end else begin
                  unload_count_d = unload_count_q + COUNT_ONE;
               end
            end else begin
               unload_count_d = unload_count_q;
            end
         end
         default: begin
            state_d = ST_LOAD;
         end
      endcase
      load_ready_d   = (state_d == ST_LOAD);
      start_d        = (state_d == ST_START);
      unload_valid_d = (state_d == ST_UNLOAD);
   end

   // State, counters and control output flops; asynchronous reset to idle LOAD.
   always_ff @(posedge clock_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state_q        <= ST_LOAD;
         load_count_q   <= '0;
         unload_count_q <= '0;
         op_count_q     <= 8'd0;
         load_ready_q   <= 1'b1;
         start_q        <= 1'b0;
         unload_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         load_count_q   <= load_count_d;
         unload_count_q <= unload_count_d;
         op_count_q     <= op_count_d;
         load_ready_q   <= load_ready_d;
         start_q        <= start_d;
         unload_valid_q <= unload_valid_d;
      end
   end

   // Register-file write port: single writes follow the load handshake in the same cycle.
   always_comb begin
      rf_non_bulk_write_enable_out = load_hs_s;
      rf_bulk_write_enable_out     = bulk_we_s;
      if (load_hs_s) begin
         rf_non_bulk_write_register_address_out = load_count_q[AW-1:0];
         rf_non_bulk_write_data_out             = load_data_in;
      end else begin
         rf_non_bulk_write_register_address_out = '0;
         rf_non_bulk_write_data_out             = 8'h00;
      end
   end

   // Unload data reads straight from the register file so the fresh bulk result shows at once.
   always_comb begin
      if (unload_valid_q) begin
         unload_data_out = rf_bytes_s[unload_count_q[AW-1:0]];
      end else begin
         unload_data_out = 8'h00;
      end
   end

   // Status outputs.
   always_comb begin
      load_ready_out      = load_ready_q;
      compute_start_out   = start_q;
      unload_valid_out    = unload_valid_q;
      operation_count_out = op_count_q;
      busy_out            = (state_q != ST_LOAD) || (load_count_q != '0);
   end

endmodule

// File: tb/tb_tensor_core_register_file_controller.sv
// Scoreboard bench for tensor_core_register_file_controller with a stub
// register file and a stub tensor core result (result[i] = 0xA0 + i).
module tb_tensor_core_register_file_controller;

   localparam int NR = 32;
   localparam int UC = 16;

   logic                        clk = 1'b0;
   logic                        rst_n;
   logic                        load_valid;
   logic [7:0]                  load_data;
   logic                        load_ready;
   logic                        unload_valid;
   logic [7:0]                  unload_data;
   logic                        unload_ready;
   logic                        start;
   logic                        done;
   logic                        wr_en;
   logic [4:0]                  wr_addr;
   logic [7:0]                  wr_data;
   logic                        bulk_en;
   logic [1:0][3:0][3:0][7:0]   rf_bus;
   logic                        busy;
   logic [7:0]                  op_count;

   logic [7:0] rf_mem [NR];

   typedef struct packed {
      logic [4:0] addr;
      logic [7:0] data;
   } wr_t;

   wr_t        wr_q[$];
   logic [7:0] un_q[$];

   int n_checks   = 0;
   int n_fail     = 0;
   int bulk_seen  = 0;
   int start_seen = 0;
   logic [7:0] exp_ops = 8'd0;
   logic [4:0] pat = 5'b01101;   // unload_ready 1,0,1,1,0 repeating

   always #5 clk = ~clk;

   tensor_core_register_file_controller #(
      .NUMBER_OF_REGISTERS(NR),
      .UNLOAD_COUNT(UC)
   ) dut (
      .clock_in(clk),
      .reset_n_in(rst_n),
      .load_valid_in(load_valid),
      .load_data_in(load_data),
      .load_ready_out(load_ready),
      .unload_valid_out(unload_valid),
      .unload_data_out(unload_data),
      .unload_ready_in(unload_ready),
      .compute_start_out(start),
      .compute_done_in(done),
      .rf_non_bulk_write_enable_out(wr_en),
      .rf_non_bulk_write_register_address_out(wr_addr),
      .rf_non_bulk_write_data_out(wr_data),
      .rf_bulk_write_enable_out(bulk_en),
      .rf_read_data_in(rf_bus),
      .busy_out(busy),
      .operation_count_out(op_count)
   );

   // Stub register file: bulk write stores the tensor core result, otherwise single writes.
   always @(posedge clk) begin
      if (bulk_en) begin
         for (int i = 0; i < NR; i++) rf_mem[i] <= 8'hA0 + 8'(i);
      end else if (wr_en) begin
         rf_mem[wr_addr] <= wr_data;
      end
   end

   // Read bus layout: byte c at [c/16][(c%16)/4][c%4].
   always_comb begin
      for (int m = 0; m < 2; m++)
         for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++)
               rf_bus[m][r][k] = rf_mem[m*16 + r*4 + k];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: pops expected writes and unload bytes whenever the DUT presents them.
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data  = 8'h00;
   always @(negedge clk) begin : monitor
      wr_t e;
      if (wr_en) begin
         if (wr_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none", wr_addr, wr_data);
         end else begin
            e = wr_q.pop_front();
            check("wr_addr", 32'(wr_addr), 32'(e.addr));
            check("wr_data", 32'(wr_data), 32'(e.data));
         end
      end
      if (bulk_en) begin
         bulk_seen++;
         check("bulk_excl_single", 32'(wr_en), 32'd0);
      end
      if (start) start_seen++;
      if (unload_valid) begin
         if (prev_stall) check("unload_stall_stable", 32'(unload_data), 32'(prev_data));
         if (unload_ready) begin
            if (un_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_unload: got 0x%0h, expected none", unload_data);
            end else begin
               check("unload_data", 32'(unload_data), 32'(un_q.pop_front()));
            end
         end
      end
      prev_stall = unload_valid && !unload_ready;
      prev_data  = unload_data;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Load NR bytes 0x00.. ; optionally with 2-cycle gaps and a done pulse in START.
   task automatic do_load(input bit toggle, input bit done_in_start);
      int sbase;
      sbase = start_seen;
      for (int i = 0; i < NR; i++) begin
         load_valid = 1'b1;
         load_data  = 8'(i);
         wr_q.push_back('{addr: 5'(i), data: 8'(i)});
         tick();
         load_valid = 1'b0;
         check("busy_during_load", 32'(busy), 32'd1);
         if (toggle && i < NR - 1) begin
            tick();
            tick();
            check("load_gap_ready", 32'(load_ready), 32'd1);
         end
      end
      done = done_in_start;
      @(negedge clk);
      check("start_pulse", 32'(start), 32'd1);
      check("start_load_ready", 32'(load_ready), 32'd0);
      check("start_no_bulk", 32'(bulk_en), 32'd0);
      tick();
      done = 1'b0;
      check("start_one_cycle", 32'(start), 32'd0);
      check("start_count", 32'(start_seen), 32'(sbase + 1));
      check("wait_no_unload", 32'(unload_valid), 32'd0);
   endtask

   // Hold in WAIT for n cycles, then pulse done and expect the result bytes.
   task automatic do_compute(input int n);
      int bbase;
      bbase = bulk_seen;
      repeat (n) tick();
      check("wait_no_bulk", 32'(bulk_seen), 32'(bbase));
      done = 1'b1;
      for (int i = 0; i < UC; i++) un_q.push_back(8'hA0 + 8'(i));
      @(negedge clk);
      check("done_bulk_en", 32'(bulk_en), 32'd1);
      tick();
      done = 1'b0;
      check("bulk_one_cycle", 32'(bulk_seen), 32'(bbase + 1));
      check("unload_entered", 32'(unload_valid), 32'd1);
      check("op_count_hold", 32'(op_count), 32'(exp_ops));
   endtask

   // Drain UC result bytes with unload_ready either patterned or held high.
   task automatic do_unload(input bit use_pat);
      int got;
      int cyc;
      got = 0;
      cyc = 0;
      while (got < UC && cyc < 400) begin
         unload_ready = use_pat ? pat[cyc % 5] : 1'b1;
         @(negedge clk);
         if (unload_valid && unload_ready) got++;
         tick();
         cyc++;
      end
      unload_ready = 1'b0;
      check("unload_handshakes", 32'(got), 32'(UC));
      exp_ops = exp_ops + 8'd1;
      check("op_count", 32'(op_count), 32'(exp_ops));
      check("back_to_load_ready", 32'(load_ready), 32'd1);
      check("back_unload_valid", 32'(unload_valid), 32'd0);
      check("back_unload_data", 32'(unload_data), 32'd0);
      check("back_busy", 32'(busy), 32'd0);
   endtask

   // Watchdog so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n        = 1'b0;
      load_valid   = 1'b1;   // must cause no write while reset is low
      load_data    = 8'h55;
      unload_ready = 1'b0;
      done         = 1'b0;
      @(negedge clk);
      check("rst_load_ready", 32'(load_ready), 32'd1);
      check("rst_unload_valid", 32'(unload_valid), 32'd0);
      check("rst_unload_data", 32'(unload_data), 32'd0);
      check("rst_start", 32'(start), 32'd0);
      check("rst_wr_en", 32'(wr_en), 32'd0);
      check("rst_bulk", 32'(bulk_en), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_op_count", 32'(op_count), 32'd0);
      tick();
      load_valid = 1'b0;
      rst_n      = 1'b1;
      tick();

      // done while idle in LOAD is ignored
      done = 1'b1;
      @(negedge clk);
      check("load_done_no_bulk", 32'(bulk_en), 32'd0);
      tick();
      done = 1'b0;
      check("load_done_stays", 32'(load_ready), 32'd1);
      check("load_done_busy", 32'(busy), 32'd0);

      // op A: back-to-back load, stray done in START, patterned unload
      do_load(1'b0, 1'b1);
      do_compute(3);
      do_unload(1'b1);

      // op B: gapped load, full-rate unload
      do_load(1'b1, 1'b0);
      do_compute(1);
      do_unload(1'b0);

      // op C: reset in the middle of WAIT
      do_load(1'b0, 1'b0);
      tick();
      tick();
      rst_n      = 1'b0;
      load_valid = 1'b1;
      load_data  = 8'h77;
      @(negedge clk);
      check("midrst_wr_en", 32'(wr_en), 32'd0);
      check("midrst_load_ready", 32'(load_ready), 32'd1);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_op_count", 32'(op_count), 32'd0);
      tick();
      load_valid = 1'b0;
      rst_n      = 1'b1;
      exp_ops    = 8'd0;
      tick();
      done = 1'b1;
      @(negedge clk);
      check("postrst_done_no_bulk", 32'(bulk_en), 32'd0);
      tick();
      done = 1'b0;
      check("postrst_load_ready", 32'(load_ready), 32'd1);
      check("postrst_unload_valid", 32'(unload_valid), 32'd0);
      do_load(1'b0, 1'b0);
      do_compute(1);
      do_unload(1'b1);

      // wrap: 255 more operations take the counter from 1 through 255 to 0
      repeat (255) begin
         do_load(1'b0, 1'b0);
         do_compute(1);
         do_unload(1'b0);
      end
      check("wrap_to_zero", 32'(op_count), 32'd0);

      check("wr_queue_empty", 32'(wr_q.size()), 32'd0);
      check("un_queue_empty", 32'(un_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tensor_core_register_file_controller.md
Name: tensor_core_register_file_controller

Overview:
- Sequences one tensor-core operation around the tensor core register file.
- Streams NUMBER_OF_REGISTERS operand bytes into the register file over a valid/ready load port using single-register writes, then pulses start to the tensor core.
- When the tensor core reports done, gates the bulk write of its result into the register file.
- Streams UNLOAD_COUNT result bytes out over a valid/ready unload port, then returns to accept the next load.

Parameters:
- NUMBER_OF_REGISTERS, 32: register file depth in bytes; must be a multiple of 16.
- UNLOAD_COUNT, 16: result bytes streamed out, from register address 0 upward; range 1..NUMBER_OF_REGISTERS.
- AW: local constant, not overridable, equal to $clog2(NUMBER_OF_REGISTERS).
- M: local constant, not overridable, equal to NUMBER_OF_REGISTERS/16.

Ports:
- clock_in  input  1  single clock; all state changes on its rising edge.
- reset_n_in  input  1  asynchronous, active-low reset.
- load_valid_in  input  1  operand byte valid.
- load_data_in  input  8  operand byte.
- load_ready_out  output  1  controller accepts an operand byte.
- unload_valid_out  output  1  result byte valid.
- unload_data_out  output  8  result byte.
- unload_ready_in  input  1  consumer accepts a result byte.
- compute_start_out  output  1  one-cycle start pulse to the tensor core.
- compute_done_in  input  1  one-cycle pulse from the tensor core; its result is valid on the bulk write bus during this cycle.
- rf_non_bulk_write_enable_out  output  1  to the register file single-register write enable.
- rf_non_bulk_write_register_address_out  output  AW  single-register write address.
- rf_non_bulk_write_data_out  output  8  single-register write data.
- rf_bulk_write_enable_out  output  1  to the register file bulk write enable.
- rf_read_data_in  input  8 x [M][4][4]  register file read bus.
- busy_out  output  1  an operation is in progress.
- operation_count_out  output  8  number of completed operations; wraps from 255 to 0.

Behaviour:
- States: LOAD, START, WAIT, UNLOAD.
- Registers:
  - state
  - load_count, AW+1 bits
  - unload_count, AW+1 bits
  - operation_count_out
- Reset (reset_n_in low, asynchronous, including mid-operation):
  - state=LOAD, both counters=0, operation_count_out=0.
  - All outputs deasserted except load_ready_out=1.
  - No register-file write is issued while reset is low.
  - Register file contents are not cleared.

LOAD:
- load_ready_out=1.
- Handshake occurs when load_valid_in=1 in this state. On a handshake, the following outputs are combinational in the same cycle:
  - rf_non_bulk_write_enable_out=1
  - address=load_count[AW-1:0]
  - data=load_data_in
- Each handshake increments load_count.
- The handshake with load_count==NUMBER_OF_REGISTERS-1 clears load_count and moves to START.
- Gaps in load_valid_in hold load_count.

START:
- compute_start_out=1 for exactly one cycle, then WAIT.
- load_ready_out=0.

WAIT:
- Holds until compute_done_in=1.
- In that cycle, rf_bulk_write_enable_out=1, combinational from compute_done_in, so the register file captures the result at that edge.
- Then UNLOAD with unload_count=0.

UNLOAD:
- unload_valid_out=1.
- unload_data_out=rf_read_data_in[c/16][(c%16)/4][c%4], where c=unload_count. Data reflects the bulk-written result from the first UNLOAD cycle.
- unload_data_out stays stable while unload_ready_in=0.
- Each handshake increments unload_count.
- The handshake at UNLOAD_COUNT-1 clears unload_count, increments operation_count_out, and returns to LOAD.

Outputs outside their state:
- compute_done_in is ignored outside WAIT; it causes no bulk write.
- rf_non_bulk_write_enable_out and rf_bulk_write_enable_out are never both 1.
- unload_valid_out=0 outside UNLOAD, and unload_data_out=0.

busy_out:
- Equals (state!=LOAD) or (load_count!=0).
- Combinational.

Timing:
- Minimum operation latency is NUMBER_OF_REGISTERS load cycles + 1 START + 1 or more WAIT + UNLOAD_COUNT cycles.
- No throughput overlap: the next load starts only after the unload completes.

Test Plan:
- Reset, then 32 back-to-back bytes 0x00..0x1F with load_valid_in held 1 → 32 single-register writes at addresses 0..31 with data==address; compute_start_out pulses exactly once, in the cycle after the 32nd write; busy_out=1 from the first accepted byte onward.
- Same load with load_valid_in toggling 1,0,0,1,... → address advances only on handshakes; exactly 32 writes; start pulse exactly once.
- compute_done_in pulsed during LOAD and during the START cycle → no bulk write and no state change. Then a done pulse in WAIT → rf_bulk_write_enable_out=1 for exactly that one cycle; state moves to UNLOAD.
- Stub tensor core writes result[i]=0xA0+i via the bulk path; unload_ready_in pattern 1,0,1,1,0,... → 16 bytes 0xA0..0xAF delivered in order; data stable across stalls; operation_count_out 0→1; load_ready_out=1 again.
- reset_n_in pulsed low mid-WAIT, then a done pulse → no bulk write; state=LOAD; operation_count_out=0; a fresh 32-byte load starts again at address 0.
- 256 consecutive operations → operation_count_out wraps from 255 to 0.
